alu_serial_sequencer: RTL and testbench

//  Sequences one external OneBitALU slice over WIDTH cycles to run a full-width
//  AND/OR/ADD/SUB/SLT, LSB first. Owns operand shift registers, the carry loop and
//  the MSB set->LSB less feedback for SLT. Sits between the issue logic and one slice.

---
 rtl/alu_serial_sequencer.sv | 147 ++++++++++++++
 tb/tb_alu_serial_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_sequencer.sv
// -----------------------------------------------------------------------------
// alu_serial_sequencer
//
// Purpose:
//    Drives a single external one-bit ALU slice for WIDTH consecutive cycles to
//    perform a full-width AND / OR / ADD / SUB / SLT, least significant bit
//    first. This block holds the operand shift registers, the slice carry
//    loop and the result shift register. It also moves the MSB "set" (adder
//    sum) bit into result bit 0 for set-less-than.
//
// Ports:
//    clk       in   1      rising-edge clock
//    rst_n     in   1      asynchronous active-low reset
//    start     in   1      operation request, sampled only while idle
//    op        in   3      op[2] = bnegate / bit-0 carry-in,
//                          op[1:0]: 00 AND, 01 OR, 10 ADD, 11 LESS
//    a, b      in   WIDTH  operands, captured on an accepted start
//    busy      out  1      high from the accept edge until done drops
//    done      out  1      one-cycle pulse, result/cout/zero valid
//    result    out  WIDTH  registered result, held until the next accept
//    cout      out  1      final MSB carry (0 for AND/OR)
//    zero      out  1      result == 0, registered alongside result
//    s_a       out  1      slice operand a (A shift register bit 0)
//    s_b       out  1      slice operand b (B shift register bit 0)
//    s_cin     out  1      slice carry-in (carry register)
//    s_less    out  1      slice less input, tied low
//    s_op      out  3      slice op (captured op)
//    s_result  in   1      slice result bit
//    s_set     in   1      slice adder sum bit
//    s_cout    in   1      slice adder carry-out
// -----------------------------------------------------------------------------
module alu_serial_sequencer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             zero,
   output logic             s_a,
   output logic             s_b,
   output logic             s_cin,
   output logic             s_less,
   output logic [2:0]       s_op,
   input  logic             s_result,
   input  logic             s_set,
   input  logic             s_cout
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_SLTFIX,
      S_DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [2:0]       op_q;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             set_msb;

   // The slice sees register bits directly, so it settles within the same
   // cycle and its outputs are consumed on the next edge.
   assign s_a    = a_sr[0];
   assign s_b    = b_sr[0];
   assign s_cin  = carry;
   assign s_less = 1'b0;
   assign s_op   = op_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         cout    <= 1'b0;
         zero    <= 1'b1;
         a_sr    <= '0;
         b_sr    <= '0;
         op_q    <= '0;
         carry   <= 1'b0;
         cnt     <= '0;
         set_msb <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  op_q  <= op;
                  // bnegate doubles as the +1 needed for two's complement
                  carry <= op[2];
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= S_RUN;
               end else begin
                  busy <= 1'b0;
               end
            end

            S_RUN: begin
               // After WIDTH shifts the first slice bit has reached bit 0.
               result <= {s_result, result[WIDTH-1:1]};
               carry  <= s_cout;
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               cnt    <= cnt + CW'(1);
               if (cnt == LAST_BIT) begin
                  cout    <= op_q[1] & s_cout;
                  set_msb <= s_set;
                  state   <= (op_q[1:0] == 2'b11) ? S_SLTFIX : S_DONE;
               end
            end

            S_SLTFIX: begin
               // SLT is the sign of a-b with no overflow correction.
               result <= {{(WIDTH-1){1'b0}}, set_msb};
               state  <= S_DONE;
            end

            S_DONE: begin
               done  <= 1'b1;
               zero  <= (result == '0);
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_serial_sequencer
//
// Self-checking bench for alu_serial_sequencer (WIDTH = 8). Contains a
// behavioural one-bit ALU slice wired to the s_* ports. Expected values come
// from a whole-word arithmetic model of the five operations.
// -----------------------------------------------------------------------------
module tb_alu_serial_sequencer;

   localparam int unsigned W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [2:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         zero;
   logic         s_a;
   logic         s_b;
   logic         s_cin;
   logic         s_less;
   logic [2:0]   s_op;
   logic         s_result;
   logic         s_set;
   logic         s_cout;

   int n_checks = 0;
   int n_fail   = 0;

   alu_serial_sequencer #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .cout     (cout),
      .zero     (zero),
      .s_a      (s_a),
      .s_b      (s_b),
      .s_cin    (s_cin),
      .s_less   (s_less),
      .s_op     (s_op),
      .s_result (s_result),
      .s_set    (s_set),
      .s_cout   (s_cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One-bit ALU slice
   logic bb;
   logic sum;
   always_comb begin
      bb     = s_b ^ s_op[2];
      sum    = s_a ^ bb ^ s_cin;
      s_set  = sum;
      s_cout = (s_a & bb) | (s_a & s_cin) | (bb & s_cin);
      case (s_op[1:0])
         2'b00:   s_result = s_a & bb;
         2'b01:   s_result = s_a | bb;
         2'b10:   s_result = sum;
         default: s_result = s_less;
      endcase
   end

   // Whole-word reference: returns {cout, result}
   function automatic logic [W:0] ref_model(input logic [2:0] o,
                                            input logic [W-1:0] x,
                                            input logic [W-1:0] y);
      logic [W-1:0] yx;
      logic [W:0]   s;
      yx = o[2] ? ~y : y;
      s  = {1'b0, x} + {1'b0, yx} + {{W{1'b0}}, o[2]};
      case (o[1:0])
         2'b00:   return {1'b0, x & yx};
         2'b01:   return {1'b0, x | yx};
         2'b10:   return s;
         default: return {s[W], {(W-1){1'b0}}, s[W-1]};
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issues one operation from a point #1 after a rising edge and returns
   // #1 after the edge on which done is sampled high. poke >= 0 re-asserts
   // start with different operands that many cycles into the run.
   task automatic run(input logic [2:0] o, input logic [W-1:0] x,
                      input logic [W-1:0] y, input int poke);
      logic [W:0] exp;
      int n;
      int lat;
      exp = ref_model(o, x, y);
      lat = (o[1:0] == 2'b11) ? W + 2 : W + 1;
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_on_accept", busy, 1);
      n = 0;
      while (!done && n < 3 * W) begin
         if (n == poke) begin
            start = 1'b1; a = ~x; b = x ^ y; op = ~o;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
      check("latency", n, lat);
      check("result", result, exp[W-1:0]);
      check("cout", cout, exp[W]);
      check("zero", zero, exp[W-1:0] == '0);
      check("busy_at_done", busy, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_zero", zero, 1);
      check("rst_cout", cout, 0);
      check("rst_less", s_less, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed cases
      run(3'b010, 8'h7F, 8'h01, -1);
      check("add_res", result, 8'h80);
      @(posedge clk); #1;
      check("idle_done", done, 0);
      check("idle_busy", busy, 0);
      run(3'b110, 8'h05, 8'h05, -1);
      check("sub_zero", zero, 1);
      run(3'b111, 8'h03, 8'h05, -1);
      check("slt_lt", result, 8'h01);
      run(3'b111, 8'h05, 8'h03, -1);
      check("slt_ge", result, 8'h00);
      run(3'b000, 8'hF0, 8'h3C, -1);
      check("and_res", result, 8'h30);
      run(3'b001, 8'hF0, 8'h3C, -1);
      check("or_res", result, 8'hFC);
      run(3'b011, 8'hC0, 8'h40, -1);
      run(3'b111, 8'h80, 8'h01, -1);

      // start re-pulsed mid-run is ignored: one done, original result
      run(3'b010, 8'h12, 8'h34, 3);
      check("poke_res", result, 8'h46);
      pulses = 0;
      repeat (3 * W) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      check("poke_extra_done", pulses, 0);

      // Reset in the middle of a run
      op = 3'b010; a = 8'h55; b = 8'h22; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_result", result, 0);
      check("mid_rst_zero", zero, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      pulses = 0;
      repeat (3 * W) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      check("mid_rst_no_done", pulses, 0);
      run(3'b010, 8'h55, 8'h22, -1);

      // Random operations, issued back-to-back
      for (int i = 0; i < 60; i++) begin
         run(3'($urandom_range(7)), 8'($urandom), 8'($urandom), -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
